// File: rtl/output_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : output_skid_buffer
// Brief    : Two-entry in-order result buffer (head + skid) with sticky overflow.
// Revision : 1.0 - initial release
// ============================================================================
module output_skid_buffer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] D,
    output logic         ready,
    output logic         valid,
    output logic [W-1:0] Q,
    input  logic         ack,
    output logic [1:0]   count,
    output logic         overflow
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] head_q,  head_d;
    logic [W-1:0] skid_q,  skid_d;
    logic         ovf_q,   ovf_d;

    // Handshake outputs depend on registered state only.
    assign ready    = (state_q != S_TWO);
    assign valid    = (state_q != S_EMPTY);
    assign Q        = head_q;
    assign overflow = ovf_q;

    always_comb begin
        case (state_q)
            S_ONE:   count = 2'd1;
            S_TWO:   count = 2'd2;
            default: count = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        ovf_d   = ovf_q | (load & ~ready);
        case (state_q)
            S_EMPTY: begin
                if (load) begin
                    head_d  = D;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                case ({load, ack})
                    2'b10: begin
                        skid_d  = D;
                        state_d = S_TWO;
                    end
                    2'b01:   state_d = S_EMPTY;
                    2'b11:   head_d  = D;
                    default: ;
                endcase
            end
            S_TWO: begin
                // Any load here is dropped; only the consumer can make progress.
                if (ack) begin
                    head_d  = skid_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            head_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            ovf_q   <= ovf_d;
        end
    end

    // The skid word is meaningless below two entries, so it is never cleared.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_output_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_skid_buffer
// Brief    : Directed and queue-model checks for output_skid_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_skid_buffer;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         load;
    logic [W-1:0] D;
    logic         ready;
    logic         valid;
    logic [W-1:0] Q;
    logic         ack;
    logic [1:0]   count;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    output_skid_buffer #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .D        (D),
        .ready    (ready),
        .valid    (valid),
        .Q        (Q),
        .ack      (ack),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        load = 1'b0;
        ack  = 1'b0;
        D    = '0;
        rst  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        load = 1'b0;
        ack  = 1'b0;
        D    = '0;
        rst  = 1'b1;
        #2;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
        total++; if (Q !== 32'h0) begin bad++; $display("FAIL reset_Q got=%h exp=0", Q); end
        total++; if (count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_first_load();
        apply_reset();
        load = 1'b1; D = 32'h3F80_0000;
        tick();
        load = 1'b0;
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", valid); end
        total++; if (Q !== 32'h3F80_0000) begin bad++; $display("FAIL first_Q got=%h exp=3f800000", Q); end
        total++; if (count !== 2'd1) begin bad++; $display("FAIL first_count got=%0d exp=1", count); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL first_ready got=%b exp=1", ready); end
    endtask

    task automatic test_fill_drain();
        apply_reset();
        // Ack while empty must be ignored.
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL idle_ack_valid got=%b exp=0", valid); end
        load = 1'b1; D = 32'hA;
        tick();
        D = 32'hB;
        tick();
        load = 1'b0;
        total++; if (count !== 2'd2) begin bad++; $display("FAIL fill_count got=%0d exp=2", count); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", ready); end
        total++; if (Q !== 32'hA) begin bad++; $display("FAIL fill_Q got=%h exp=a", Q); end
        tick();
        total++; if (Q !== 32'hA) begin bad++; $display("FAIL hold_Q got=%h exp=a", Q); end
        ack = 1'b1;
        tick();
        total++; if (Q !== 32'hB) begin bad++; $display("FAIL drain1_Q got=%h exp=b", Q); end
        total++; if (count !== 2'd1) begin bad++; $display("FAIL drain1_count got=%0d exp=1", count); end
        tick();
        ack = 1'b0;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL drain2_valid got=%b exp=0", valid); end
        total++; if (count !== 2'd0) begin bad++; $display("FAIL drain2_count got=%0d exp=0", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL drain_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_load_ack_one();
        apply_reset();
        load = 1'b1; D = 32'h1;
        tick();
        ack = 1'b1; D = 32'h2;
        tick();
        load = 1'b0; ack = 1'b0;
        total++; if (Q !== 32'h2) begin bad++; $display("FAIL one_swap_Q got=%h exp=2", Q); end
        total++; if (count !== 2'd1) begin bad++; $display("FAIL one_swap_count got=%0d exp=1", count); end
    endtask

    task automatic test_overflow_two();
        apply_reset();
        load = 1'b1; D = 32'h5;
        tick();
        D = 32'h6;
        tick();
        D = 32'h7; ack = 1'b1;
        tick();
        load = 1'b0; ack = 1'b0;
        total++; if (Q !== 32'h6) begin bad++; $display("FAIL ovf_Q got=%h exp=6", Q); end
        total++; if (count !== 2'd1) begin bad++; $display("FAIL ovf_count got=%0d exp=1", count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL ovf_drain_valid got=%b exp=0 Q=%h", valid, Q); end
        tick();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        load = 1'b1; D = 32'h11;
        tick();
        D = 32'h22;
        tick();
        // Overflow also set so the reset must visibly clear it.
        D = 32'h33;
        tick();
        load = 1'b0;
        total++; if (count !== 2'd2) begin bad++; $display("FAIL ar_pre_count got=%0d exp=2", count); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", valid); end
        total++; if (Q !== 32'h0) begin bad++; $display("FAIL ar_Q got=%h exp=0", Q); end
        total++; if (count !== 2'd0) begin bad++; $display("FAIL ar_count got=%0d exp=0", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ar_overflow got=%b exp=0", overflow); end
        tick();
        rst = 1'b0;
        load = 1'b1; D = 32'h44;
        tick();
        load = 1'b0;
        total++; if (Q !== 32'h44 || count !== 2'd1) begin bad++; $display("FAIL ar_after Q=%h count=%0d exp Q=44 count=1", Q, count); end
    endtask

    task automatic test_random();
        logic [W-1:0] mq[$];
        int           dropped;
        int           errs;
        logic         l, a;
        logic [W-1:0] d;
        apply_reset();
        dropped = 0;
        errs    = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            l = 1'($urandom_range(0, 1));
            a = 1'($urandom_range(0, 1));
            d = $urandom;
            load = l; ack = a; D = d;
            if (a && mq.size() > 0) begin
                if (l && mq.size() >= 2) dropped++;
                if (l && mq.size() < 2) begin
                    void'(mq.pop_front());
                    mq.push_back(d);
                end else begin
                    void'(mq.pop_front());
                end
            end else if (l) begin
                if (mq.size() < 2) mq.push_back(d);
                else dropped++;
            end
            tick();
            total++;
            if (count !== 2'(mq.size()) || valid !== (mq.size() > 0) || ready !== (mq.size() < 2) ||
                (mq.size() > 0 && Q !== mq[0])) begin
                bad++;
                if (errs < 10)
                    $display("FAIL rand_cyc%0d got count=%0d valid=%b ready=%b Q=%h exp count=%0d head=%h",
                             cyc, count, valid, ready, Q, mq.size(), (mq.size() > 0) ? mq[0] : '0);
                errs++;
            end
            total++;
            if (overflow !== (dropped != 0)) begin
                bad++;
                if (errs < 10) $display("FAIL rand_ovf_cyc%0d got=%b exp=%b", cyc, overflow, dropped != 0);
                errs++;
            end
        end
        load = 1'b0; ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; ack = 1'b0; D = '0;
        test_reset();
        test_first_load();
        test_fill_drain();
        test_load_ack_one();
        test_overflow_two();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
